// File: rtl/irq_encoder16_to_4_if.sv
// Request/grant bundle between interrupt sources, the 16:4 encoder and the control unit.
interface irq_encoder16_to_4_if;
  logic [15:0] req;
  logic [15:0] mask;
  logic        ack;
  logic [3:0]  code;
  logic        valid;
  logic [15:0] pending;
  logic        overrun;

  modport master (
    output req, mask, ack,
    input  code, valid, pending, overrun
  );

  modport slave (
    input  req, mask, ack,
    output code, valid, pending, overrun
  );
endinterface

// File: rtl/irq_encoder16_to_4.sv
// Registered 16:4 priority encoder: latches request rising edges as pending and presents
// the highest unmasked one as a frozen code until the control unit acknowledges it.
module irq_encoder16_to_4 (
  input  logic                  clk,
  input  logic                  reset,
  irq_encoder16_to_4_if.slave   bus
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t      state_q, state_d;
  logic [15:0] req_q, req_d;
  logic [15:0] pending_q, pending_d;
  logic [3:0]  code_q, code_d;
  logic        overrun_q, overrun_d;

  logic [15:0] rise;
  logic [15:0] clr;
  logic [15:0] elig;

  // Bit 15 wins: later (higher) set bits overwrite the result.
  function automatic logic [3:0] prio_idx(input logic [15:0] e);
    logic [3:0] p;
    p = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (e[i]) p = 4'(i);
    end
    return p;
  endfunction

  always_comb begin
    req_d     = bus.req;
    rise      = bus.req & ~req_q;
    clr       = 16'h0000;
    if (state_q == PRESENT && bus.ack) clr[code_q] = 1'b1;
    // A rise on the bit being cleared keeps it pending (set wins).
    pending_d = (pending_q & ~clr) | rise;
    overrun_d = |(rise & pending_q & ~clr);
    elig      = pending_q & ~bus.mask;
    state_d   = state_q;
    code_d    = code_q;
    case (state_q)
      IDLE: begin
        if (elig != 16'h0000) begin
          code_d  = prio_idx(elig);
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= 16'h0000;
      pending_q <= 16'h0000;
      code_q    <= 4'h0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.code    = code_q;
  assign bus.valid   = (state_q == PRESENT);
  assign bus.pending = pending_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_irq_encoder16_to_4.sv
// Bench for irq_encoder16_to_4: directed vectors, expected grant codes queued at stimulus
// time and matched by a monitor on each valid rising edge; cycle-level checks inline.
module tb_irq_encoder16_to_4;

  logic clk;
  logic reset;
  irq_encoder16_to_4_if bus ();

  irq_encoder16_to_4 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];
  logic       prev_valid = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every new grant must match the next queued expected code.
  always @(negedge clk) begin
    if (bus.valid === 1'b1 && !prev_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL grant_unexpected: got code=%h want=no grant at %0t", bus.code, $time);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (bus.code !== e) begin
          bad++;
          $display("FAIL grant_code: got=%h want=%h at %0t", bus.code, e, $time);
        end
      end
    end
    prev_valid = (bus.valid === 1'b1);
  end

  initial begin
    logic [3:0] order [4];
    order[0] = 4'd15; order[1] = 4'd10; order[2] = 4'd5; order[3] = 4'd0;

    reset = 1'b1;
    bus.req = 16'h0; bus.mask = 16'h0; bus.ack = 1'b0;
    step(1);
    chk("rst_code", 16'(bus.code), 16'h0);
    chk("rst_valid", 16'(bus.valid), 16'h0);
    chk("rst_pending", bus.pending, 16'h0);
    chk("rst_overrun", 16'(bus.overrun), 16'h0);
    step(1);
    reset = 1'b0;
    step(1);

    // 1: single request, latency and ack
    bus.req = 16'h0008; exp_q.push_back(4'h3);
    step(1); bus.req = 16'h0;
    chk("t1_pend_E0", bus.pending, 16'h0008);
    chk("t1_valid_E0", 16'(bus.valid), 16'h0);
    step(1);
    chk("t1_valid_E1", 16'(bus.valid), 16'h1);
    chk("t1_code_E1", 16'(bus.code), 16'h3);
    bus.ack = 1'b1; step(1); bus.ack = 1'b0;
    chk("t1_valid_ack", 16'(bus.valid), 16'h0);
    chk("t1_pend_ack", bus.pending, 16'h0);

    // 2: priority order 15,10,5,0
    bus.req = 16'h8421;
    for (int j = 0; j < 4; j++) exp_q.push_back(order[j]);
    step(1); bus.req = 16'h0;
    chk("t2_pend", bus.pending, 16'h8421);
    step(1);
    for (int j = 0; j < 4; j++) begin
      chk("t2_valid", 16'(bus.valid), 16'h1);
      chk("t2_code", 16'(bus.code), 16'(order[j]));
      bus.ack = 1'b1; step(1); bus.ack = 1'b0;
      chk("t2_valid_drop", 16'(bus.valid), 16'h0);
      if (j < 3) step(1);
    end
    chk("t2_pend_end", bus.pending, 16'h0);

    // 3: presented code frozen against higher-priority arrival
    bus.req = 16'h0004; exp_q.push_back(4'h2); exp_q.push_back(4'hC);
    step(1); bus.req = 16'h0;
    step(1);
    chk("t3_code", 16'(bus.code), 16'h2);
    bus.req = 16'h1000;
    step(1); bus.req = 16'h0;
    chk("t3_pend", bus.pending, 16'h1004);
    for (int j = 0; j < 4; j++) begin
      step(1);
      chk("t3_frozen_code", 16'(bus.code), 16'h2);
      chk("t3_frozen_valid", 16'(bus.valid), 16'h1);
    end
    chk("t3_pend_hold", bus.pending, 16'h1004);
    bus.ack = 1'b1; step(1); bus.ack = 1'b0;
    chk("t3_pend_ack", bus.pending, 16'h1000);
    step(1);
    chk("t3_next_code", 16'(bus.code), 16'hC);
    bus.ack = 1'b1; step(1); bus.ack = 1'b0;
    chk("t3_pend_end", bus.pending, 16'h0);

    // 4: masked source waits until mask clears
    bus.mask = 16'h0020; bus.req = 16'h0030;
    exp_q.push_back(4'h4); exp_q.push_back(4'h5);
    step(1); bus.req = 16'h0;
    chk("t4_pend", bus.pending, 16'h0030);
    step(1);
    chk("t4_code4", 16'(bus.code), 16'h4);
    bus.ack = 1'b1; step(1); bus.ack = 1'b0;
    step(2);
    chk("t4_masked_valid", 16'(bus.valid), 16'h0);
    chk("t4_masked_pend", bus.pending, 16'h0020);
    bus.mask = 16'h0;
    step(1);
    chk("t4_unmask_valid", 16'(bus.valid), 16'h1);
    chk("t4_unmask_code", 16'(bus.code), 16'h5);
    bus.ack = 1'b1; step(1); bus.ack = 1'b0;
    chk("t4_pend_end", bus.pending, 16'h0);

    // 5a: re-rise coincident with ack clearing the same bit
    bus.req = 16'h0008; exp_q.push_back(4'h3); exp_q.push_back(4'h3);
    step(1); bus.req = 16'h0;
    step(1);
    bus.req = 16'h0008; bus.ack = 1'b1;
    step(1); bus.req = 16'h0; bus.ack = 1'b0;
    chk("t5a_pend", bus.pending, 16'h0008);
    chk("t5a_overrun", 16'(bus.overrun), 16'h0);
    chk("t5a_valid", 16'(bus.valid), 16'h0);
    step(1);
    chk("t5a_regrant", 16'(bus.code), 16'h3);
    bus.ack = 1'b1; step(1); bus.ack = 1'b0;
    chk("t5a_pend_end", bus.pending, 16'h0);

    // 5b: duplicate edge on pending source pulses overrun once
    bus.req = 16'h0080; exp_q.push_back(4'h7);
    step(1); bus.req = 16'h0;
    chk("t5b_overrun_first", 16'(bus.overrun), 16'h0);
    step(1);
    bus.req = 16'h0080;
    step(1); bus.req = 16'h0;
    chk("t5b_overrun_pulse", 16'(bus.overrun), 16'h1);
    chk("t5b_pend", bus.pending, 16'h0080);
    step(1);
    chk("t5b_overrun_end", 16'(bus.overrun), 16'h0);
    bus.ack = 1'b1; step(1); bus.ack = 1'b0;
    chk("t5b_pend_end", bus.pending, 16'h0);

    // 6: reset mid-PRESENT with requests held through reset
    bus.req = 16'h0201;
    exp_q.push_back(4'h9); exp_q.push_back(4'h9); exp_q.push_back(4'h0);
    step(2);
    chk("t6_code", 16'(bus.code), 16'h9);
    chk("t6_pend", bus.pending, 16'h0201);
    reset = 1'b1; step(1); reset = 1'b0;
    chk("t6_rst_code", 16'(bus.code), 16'h0);
    chk("t6_rst_valid", 16'(bus.valid), 16'h0);
    chk("t6_rst_pend", bus.pending, 16'h0);
    chk("t6_rst_overrun", 16'(bus.overrun), 16'h0);
    step(1);
    chk("t6_post_pend", bus.pending, 16'h0201);
    chk("t6_post_valid", 16'(bus.valid), 16'h0);
    step(1);
    chk("t6_regrant", 16'(bus.code), 16'h9);
    bus.req = 16'h0;
    bus.ack = 1'b1; step(1); bus.ack = 1'b0;
    step(1);
    chk("t6_last_code", 16'(bus.code), 16'h0);
    bus.ack = 1'b1; step(1); bus.ack = 1'b0;
    step(3);
    chk("t6_pend_end", bus.pending, 16'h0);
    chk("grants_left", 16'(exp_q.size()), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
